// File: rtl/ff_d_pipe.sv
// WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tags,
// stall (en), flush, synchronous reset and a registered count of valid stages.
module ff_d_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int unsigned     OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;

    // One word may enter and one may leave per enabled edge, so the count
    // stays within 0..DEPTH and never wraps.
    always_comb begin
        occ_next = occ + OCC_W'(d_valid) - OCC_W'(vld[DEPTH-1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data stages are plain flops, not a RAM, so they are
            // reset too; downstream never sees X after reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                data[i] <= RST_VAL;
            end
            vld <= '0;
            occ <= '0;
        end else if (flush) begin
            vld <= '0;
            occ <= '0;
        end else if (en) begin
            data[0] <= d;
            vld[0]  <= d_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
            occ <= occ_next;
        end
    end

    assign q         = data[DEPTH-1];
    assign q_valid   = vld[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_ff_d_pipe.sv
// Self-checking bench for ff_d_pipe: a DEPTH=3 and a DEPTH=1 instance share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_ff_d_pipe;

    localparam logic [7:0] RV3 = 8'hA5;
    localparam logic [7:0] RV1 = 8'h5A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_valid = 1'b0;

    logic [7:0] q3, q1;
    logic       qv3, qv1;
    logic [1:0] occ3;
    logic [0:0] occ1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ff_d_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(RV3)) u3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q3), .q_valid(qv3), .occupancy(occ3)
    );

    ff_d_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV1)) u1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .occupancy(occ1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pipe is the list of the last DEPTH accepted words,
    // newest first; the output is the oldest one.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;
    typedef ent_t ent_q_t[$];

    ent_q_t m3, m1;
    bit     model_ok = 1'b0;

    function automatic ent_q_t step(input ent_q_t m, input int depth, input logic [7:0] rv,
                                    input logic r, input logic f, input logic e,
                                    input logic [7:0] din, input logic dv);
        ent_q_t n;
        ent_t   x;
        n = m;
        if (r) begin
            n = {};
            x.d = rv;
            x.v = 1'b0;
            for (int i = 0; i < depth; i++) n.push_back(x);
        end else if (n.size() == 0) begin
            return n;
        end else if (f) begin
            foreach (n[i]) n[i].v = 1'b0;
        end else if (e) begin
            x.d = din;
            x.v = dv;
            n.push_front(x);
            void'(n.pop_back());
        end
        return n;
    endfunction

    function automatic int count_valid(input ent_q_t m);
        int c = 0;
        foreach (m[i]) if (m[i].v) c++;
        return c;
    endfunction

    always @(posedge clk) begin
        m3 = step(m3, 3, RV3, rst, flush, en, d, d_valid);
        m1 = step(m1, 1, RV1, rst, flush, en, d, d_valid);
        if (rst) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("d3_q",   32'(q3),   32'(m3[$].d));
            check("d3_qv",  32'(qv3),  32'(m3[$].v));
            check("d3_occ", 32'(occ3), 32'(count_valid(m3)));
            check("d1_q",   32'(q1),   32'(m1[$].d));
            check("d1_qv",  32'(qv1),  32'(m1[$].v));
            check("d1_occ", 32'(occ1), 32'(count_valid(m1)));
        end
    end

    // Drive inputs on the falling edge, let one rising edge pass, settle.
    task automatic cyc(input logic r, input logic f, input logic e,
                       input logic [7:0] din, input logic dv);
        @(negedge clk);
        rst     = r;
        flush   = f;
        en      = e;
        d       = din;
        d_valid = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset
        cyc(1, 0, 0, 8'h00, 0);
        check("rst_q3",   32'(q3),   32'hA5);
        check("rst_qv3",  32'(qv3),  32'h0);
        check("rst_occ3", 32'(occ3), 32'h0);
        check("rst_q1",   32'(q1),   32'h5A);

        // 2: fill and stream
        cyc(0, 0, 1, 8'h11, 1);
        check("fill1_occ3", 32'(occ3), 32'd1);
        check("fill1_q1",   32'(q1),   32'h11);
        check("fill1_qv1",  32'(qv1),  32'h1);
        check("fill1_occ1", 32'(occ1), 32'd1);
        cyc(0, 0, 1, 8'h22, 1);
        check("fill2_occ3", 32'(occ3), 32'd2);
        check("fill2_qv3",  32'(qv3),  32'h0);
        cyc(0, 0, 1, 8'h33, 1);
        check("fill3_q3",   32'(q3),   32'h11);
        check("fill3_qv3",  32'(qv3),  32'h1);
        check("fill3_occ3", 32'(occ3), 32'd3);
        cyc(0, 0, 1, 8'h44, 1);
        check("fill4_q3",   32'(q3),   32'h22);
        check("fill4_occ3", 32'(occ3), 32'd3);
        cyc(0, 0, 1, 8'h55, 1);
        check("fill5_q3",   32'(q3),   32'h33);

        // 3: stall with toggling input
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h11, 1);
        cyc(0, 0, 1, 8'h22, 1);
        cyc(0, 0, 1, 8'h33, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, (i % 2) ? 8'hFF : 8'h00, i[0]);
            check("stall_q3",   32'(q3),   32'h11);
            check("stall_occ3", 32'(occ3), 32'd3);
        end
        cyc(0, 0, 1, 8'h44, 1);
        check("resume_q3", 32'(q3), 32'h22);

        // 4: flush wins over en; data retained, valids cleared
        cyc(0, 1, 1, 8'h77, 1);
        check("flush_q3",   32'(q3),   32'h22);
        check("flush_qv3",  32'(qv3),  32'h0);
        check("flush_occ3", 32'(occ3), 32'd0);
        check("flush_occ1", 32'(occ1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 8'h00, 0);
            check("post_flush_qv3", 32'(qv3), 32'h0);
        end

        // 5: mixed valid V,I,V
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h01, 1);
        check("mix1_occ3", 32'(occ3), 32'd1);
        cyc(0, 0, 1, 8'h02, 0);
        check("mix2_occ3", 32'(occ3), 32'd1);
        cyc(0, 0, 1, 8'h03, 1);
        check("mix3_occ3", 32'(occ3), 32'd2);
        check("mix3_qv3",  32'(qv3),  32'h1);
        cyc(0, 0, 1, 8'h00, 0);
        check("mix4_qv3",  32'(qv3),  32'h0);
        check("mix4_q3",   32'(q3),   32'h02);
        cyc(0, 0, 1, 8'h00, 0);
        check("mix5_qv3",  32'(qv3),  32'h1);
        check("mix5_q3",   32'(q3),   32'h03);

        // 6: reset beats flush and en mid-stream
        cyc(0, 0, 1, 8'h66, 1);
        cyc(1, 1, 1, 8'h99, 1);
        check("rst_mid_q3",   32'(q3),   32'hA5);
        check("rst_mid_qv3",  32'(qv3),  32'h0);
        check("rst_mid_occ3", 32'(occ3), 32'd0);
        check("rst_mid_q1",   32'(q1),   32'h5A);
        check("rst_mid_qv1",  32'(qv1),  32'h0);

        // Randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0),
                8'($urandom),
                1'($urandom));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
